wb_trap_ctrl: RTL and testbench

//  Write-back stage trap sequencer. Accepts one retiring instruction per cycle from WB, prioritises

---
 rtl/wb_trap_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_wb_trap_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trap_ctrl.sv
// wb_trap_ctrl: write-back stage trap sequencer.
// Takes one retiring instruction per cycle from WB. It ranks exceptions above
// mret and mret above interrupts. It then runs a fixed IDLE -> TRAP -> REDIRECT
// sequence that writes mcause/mtval/mepc/mstatus for one cycle and holds a PC
// redirect until the fetch controller acknowledges it.
// Optional feature macro: WB_TRAP_VECTORED_EN. When it is defined, an
// interrupt taken with mtvec mode 2'b01 vectors to base + 4*cause.
module wb_trap_ctrl #(
    parameter int XLEN    = 64,
    parameter int NUM_IRQ = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_valid_i,
    output logic               wb_ready_o,
    input  logic [XLEN-1:0]    wb_pc_i,
    input  logic [31:0]        wb_instr_i,
    input  logic [9:0]         wb_excp_i,
    input  logic [XLEN-1:0]    wb_badaddr_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] mie_rdata_i,
    input  logic               mstatus_mie_i,
    input  logic               mstatus_mpie_i,
    input  logic [XLEN-1:0]    mtvec_rdata_i,
    input  logic [XLEN-1:0]    mepc_rdata_i,
    output logic               commit_o,
    output logic [NUM_IRQ-1:0] mip_o,
    output logic               mcause_wen_o,
    output logic [XLEN-1:0]    mcause_wdata_o,
    output logic               mtval_wen_o,
    output logic [XLEN-1:0]    mtval_wdata_o,
    output logic               mepc_wen_o,
    output logic [XLEN-1:0]    mepc_wdata_o,
    output logic               mstatus_wen_o,
    output logic               mstatus_mie_o,
    output logic               mstatus_mpie_o,
    output logic               redirect_valid_o,
    output logic [XLEN-1:0]    redirect_pc_o,
    input  logic               redirect_ready_i
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        TRAP     = 2'b01,
        REDIRECT = 2'b10
    } state_t;

    // Exception bit positions in wb_excp_i.
    localparam int E_PC_MIS = 0;
    localparam int E_IF_BUS = 1;
    localparam int E_ILEGL  = 2;
    localparam int E_ECALL  = 3;
    localparam int E_EBREAK = 4;
    localparam int E_MRET   = 5;
    localparam int E_LD_MIS = 6;
    localparam int E_LD_BUS = 7;
    localparam int E_ST_MIS = 8;
    localparam int E_ST_BUS = 9;

    state_t            state_r, state_nxt_s;
    logic [NUM_IRQ-1:0] mip_r;
    logic              exc_any_s, take_mret_s, take_irq_s, accept_s, commit_s;
    logic [NUM_IRQ-1:0] pend_vec_s;
    logic              irq_pend_s;
    logic [5:0]        exc_code_s, irq_code_s;
    logic [XLEN-1:0]   exc_tval_s, base_s;
    logic [XLEN-1:0]   cause_s, tval_s, epc_s, target_s, target_r;

    // Lowest-numbered pending line wins; result is the interrupt cause code 16+idx.
    function automatic logic [5:0] irq_code_f(input logic [NUM_IRQ-1:0] p);
        logic [5:0] c;
        c = 6'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (p[i]) begin
                c = 6'(16 + i);
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

    assign exc_any_s   = |{wb_excp_i[9:6], wb_excp_i[4:0]};
    assign pend_vec_s  = mip_r & mie_rdata_i;
    assign irq_pend_s  = (|pend_vec_s) & mstatus_mie_i;
    assign irq_code_s  = irq_code_f(pend_vec_s);
    assign take_mret_s = !exc_any_s && wb_excp_i[E_MRET];
    assign take_irq_s  = !exc_any_s && !wb_excp_i[E_MRET] && irq_pend_s;
    assign accept_s    = (state_r == IDLE) && wb_valid_i &&
                         (exc_any_s || wb_excp_i[E_MRET] || irq_pend_s);
    assign commit_s    = (state_r == IDLE) && !rst && wb_valid_i &&
                         !exc_any_s && !wb_excp_i[E_MRET];
    // Mode bits are masked off instead of being sliced away.
    assign base_s      = mtvec_rdata_i & ~XLEN'(3);

    assign wb_ready_o  = (state_r == IDLE);
    assign commit_o    = commit_s;
    assign mip_o       = mip_r;

    // Fixed exception priority and the matching mtval source.
    always_comb begin
        exc_code_s = 6'd0;
        exc_tval_s = wb_badaddr_i;
        if (wb_excp_i[E_IF_BUS]) begin
            exc_code_s = 6'd1;
        end else if (wb_excp_i[E_PC_MIS]) begin
            exc_code_s = 6'd0;
        end else if (wb_excp_i[E_ILEGL]) begin
            exc_code_s = 6'd2;
            exc_tval_s = XLEN'(wb_instr_i);
        end else if (wb_excp_i[E_ECALL]) begin
            exc_code_s = 6'd11;
            exc_tval_s = '0;
        end else if (wb_excp_i[E_EBREAK]) begin
            exc_code_s = 6'd3;
            exc_tval_s = '0;
        end else if (wb_excp_i[E_LD_MIS]) begin
            exc_code_s = 6'd4;
        end else if (wb_excp_i[E_ST_MIS]) begin
            exc_code_s = 6'd6;
        end else if (wb_excp_i[E_LD_BUS]) begin
            exc_code_s = 6'd5;
        end else if (wb_excp_i[E_ST_BUS]) begin
            exc_code_s = 6'd7;
        end else begin
            exc_code_s = 6'd0;
        end
    end

    // Trap context for the instruction being accepted: cause, tval, epc and target.
    always_comb begin
        cause_s  = '0;
        tval_s   = '0;
        epc_s    = '0;
        target_s = base_s;
        if (take_mret_s) begin
            target_s = mepc_rdata_i;
        end else if (take_irq_s) begin
            cause_s  = {1'b1, {(XLEN-7){1'b0}}, irq_code_s};
            epc_s    = wb_pc_i + XLEN'(4);
`ifdef WB_TRAP_VECTORED_EN
            if (mtvec_rdata_i[1:0] == 2'b01) begin
                target_s = base_s + (XLEN'(irq_code_s) << 2);
            end else begin
                target_s = base_s;
            end
`else
            target_s = base_s;
`endif
        end else begin
            cause_s  = XLEN'(exc_code_s);
            tval_s   = exc_tval_s;
            epc_s    = wb_pc_i;
        end
    end

    // Next-state logic for the trap sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = TRAP;
                else          state_nxt_s = IDLE;
            end
            TRAP:     state_nxt_s = REDIRECT;
            REDIRECT: begin
                if (redirect_ready_i) state_nxt_s = IDLE;
                else                  state_nxt_s = REDIRECT;
            end
            default:  state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nxt_s;
    end

    // Interrupt lines are sampled every cycle regardless of state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mip_r <= '0;
        else     mip_r <= irq_i;
    end

    // CSR write strobes and data: loaded on the accept edge and cleared after the TRAP cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcause_wen_o   <= 1'b0;
            mcause_wdata_o <= '0;
            mtval_wen_o    <= 1'b0;
            mtval_wdata_o  <= '0;
            mepc_wen_o     <= 1'b0;
            mepc_wdata_o   <= '0;
            mstatus_wen_o  <= 1'b0;
            mstatus_mie_o  <= 1'b0;
            mstatus_mpie_o <= 1'b0;
            target_r       <= '0;
        end else if (accept_s) begin
            mcause_wen_o   <= !take_mret_s;
            mcause_wdata_o <= cause_s;
            mtval_wen_o    <= !take_mret_s;
            mtval_wdata_o  <= tval_s;
            mepc_wen_o     <= !take_mret_s;
            mepc_wdata_o   <= epc_s;
            mstatus_wen_o  <= 1'b1;
            mstatus_mie_o  <= take_mret_s ? mstatus_mpie_i : 1'b0;
            mstatus_mpie_o <= take_mret_s ? 1'b1 : mstatus_mie_i;
            target_r       <= target_s;
        end else if (state_r == TRAP) begin
            mcause_wen_o   <= 1'b0;
            mcause_wdata_o <= '0;
            mtval_wen_o    <= 1'b0;
            mtval_wdata_o  <= '0;
            mepc_wen_o     <= 1'b0;
            mepc_wdata_o   <= '0;
            mstatus_wen_o  <= 1'b0;
            mstatus_mie_o  <= 1'b0;
            mstatus_mpie_o <= 1'b0;
        end
    end

    // Redirect handshake: raised when leaving TRAP, held until the controller accepts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else if (state_r == TRAP) begin
            redirect_valid_o <= 1'b1;
            redirect_pc_o    <= target_r;
        end else if ((state_r == REDIRECT) && redirect_ready_i) begin
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end
    end

endmodule

// File: tb/tb_wb_trap_ctrl.sv
// Testbench for wb_trap_ctrl: directed trap scenarios. Expected CSR writes and
// redirect targets go into queues, and a monitor checks them as the DUT
// presents them.
module tb_wb_trap_ctrl;
    localparam int XLEN    = 64;
    localparam int NUM_IRQ = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               wb_valid_i, wb_ready_o;
    logic [XLEN-1:0]    wb_pc_i, wb_badaddr_i, mtvec_rdata_i, mepc_rdata_i;
    logic [31:0]        wb_instr_i;
    logic [9:0]         wb_excp_i;
    logic [NUM_IRQ-1:0] irq_i, mie_rdata_i, mip_o;
    logic               mstatus_mie_i, mstatus_mpie_i, commit_o;
    logic               mcause_wen_o, mtval_wen_o, mepc_wen_o;
    logic [XLEN-1:0]    mcause_wdata_o, mtval_wdata_o, mepc_wdata_o;
    logic               mstatus_wen_o, mstatus_mie_o, mstatus_mpie_o;
    logic               redirect_valid_o, redirect_ready_i;
    logic [XLEN-1:0]    redirect_pc_o;

    wb_trap_ctrl #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) dut (
        .clk(clk), .rst(rst),
        .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
        .wb_pc_i(wb_pc_i), .wb_instr_i(wb_instr_i), .wb_excp_i(wb_excp_i),
        .wb_badaddr_i(wb_badaddr_i), .irq_i(irq_i), .mie_rdata_i(mie_rdata_i),
        .mstatus_mie_i(mstatus_mie_i), .mstatus_mpie_i(mstatus_mpie_i),
        .mtvec_rdata_i(mtvec_rdata_i), .mepc_rdata_i(mepc_rdata_i),
        .commit_o(commit_o), .mip_o(mip_o),
        .mcause_wen_o(mcause_wen_o), .mcause_wdata_o(mcause_wdata_o),
        .mtval_wen_o(mtval_wen_o), .mtval_wdata_o(mtval_wdata_o),
        .mepc_wen_o(mepc_wen_o), .mepc_wdata_o(mepc_wdata_o),
        .mstatus_wen_o(mstatus_wen_o), .mstatus_mie_o(mstatus_mie_o),
        .mstatus_mpie_o(mstatus_mpie_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .redirect_ready_i(redirect_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            csr_wen;   // mcause/mtval/mepc written (0 for mret)
        logic [XLEN-1:0] mc, mt, me;
        logic            mie, mpie;
    } trap_t;

    trap_t           trap_q[$];
    logic [XLEN-1:0] redir_q[$];
    int              errors = 0;
    int              checks = 0;
    logic            redir_prev = 1'b0;
    logic [XLEN-1:0] redir_cur  = '0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_trap(input logic csr_wen, input logic [XLEN-1:0] mc, input logic [XLEN-1:0] mt,
                            input logic [XLEN-1:0] me, input logic mie, input logic mpie,
                            input logic [XLEN-1:0] target);
        trap_t t;
        t.csr_wen = csr_wen; t.mc = mc; t.mt = mt; t.me = me; t.mie = mie; t.mpie = mpie;
        trap_q.push_back(t);
        redir_q.push_back(target);
    endtask

    // Monitor: checks each CSR write cycle and each redirect against the queues.
    always @(negedge clk) begin
        if (rst) begin
            redir_prev = 1'b0;
        end else begin
            if (mcause_wen_o || mtval_wen_o || mepc_wen_o || mstatus_wen_o) begin
                if (trap_q.size() == 0) begin
                    chk("unexpected_trap", 64'(mstatus_wen_o), 64'd0);
                end else begin
                    trap_t t;
                    t = trap_q.pop_front();
                    chk("mcause_wen", 64'(mcause_wen_o), 64'(t.csr_wen));
                    chk("mtval_wen", 64'(mtval_wen_o), 64'(t.csr_wen));
                    chk("mepc_wen", 64'(mepc_wen_o), 64'(t.csr_wen));
                    chk("mstatus_wen", 64'(mstatus_wen_o), 64'd1);
                    if (t.csr_wen) begin
                        chk("mcause", mcause_wdata_o, t.mc);
                        chk("mtval", mtval_wdata_o, t.mt);
                        chk("mepc", mepc_wdata_o, t.me);
                    end
                    chk("mstatus_mie", 64'(mstatus_mie_o), 64'(t.mie));
                    chk("mstatus_mpie", 64'(mstatus_mpie_o), 64'(t.mpie));
                end
            end
            if (redirect_valid_o && !redir_prev) begin
                if (redir_q.size() == 0) begin
                    chk("unexpected_redirect", redirect_pc_o, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    redir_cur = redir_q.pop_front();
                    chk("redirect_pc", redirect_pc_o, redir_cur);
                end
            end else if (redirect_valid_o) begin
                chk("redirect_pc_stable", redirect_pc_o, redir_cur);
            end
            redir_prev = redirect_valid_o;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!wb_ready_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", 64'(wb_ready_o), 64'd1);
    endtask

    task automatic drive(input logic [XLEN-1:0] pc, input logic [31:0] instr,
                         input logic [9:0] excp, input logic [XLEN-1:0] bad);
        wb_valid_i = 1'b1; wb_pc_i = pc; wb_instr_i = instr;
        wb_excp_i = excp; wb_badaddr_i = bad;
    endtask

    task automatic do_trap(input logic [XLEN-1:0] pc, input logic [31:0] instr, input logic [9:0] excp,
                           input logic [XLEN-1:0] bad, input logic exp_commit,
                           input int ready_delay, input logic drop_irq);
        wait_ready();
        drive(pc, instr, excp, bad);
        #1;
        chk("commit", 64'(commit_o), 64'(exp_commit));
        @(posedge clk); #1;
        wb_valid_i = 1'b0; wb_excp_i = 10'd0;
        if (drop_irq) irq_i = '0;
        chk("ready_in_trap", 64'(wb_ready_o), 64'd0);
        chk("redir_early", 64'(redirect_valid_o), 64'd0);
        @(posedge clk); #1;
        chk("redir_rise", 64'(redirect_valid_o), 64'd1);
        for (int i = 0; i < ready_delay; i++) begin
            @(posedge clk); #1;
            chk("redir_hold", 64'(redirect_valid_o), 64'd1);
            chk("ready_in_redir", 64'(wb_ready_o), 64'd0);
        end
        redirect_ready_i = 1'b1;
        @(posedge clk); #1;
        redirect_ready_i = 1'b0;
        chk("idle_after_ack", 64'(wb_ready_o), 64'd1);
        chk("redir_drop", 64'(redirect_valid_o), 64'd0);
    endtask

    task automatic do_commit(input logic [XLEN-1:0] pc);
        wait_ready();
        drive(pc, 32'h0000_0013, 10'd0, 64'd0);
        #1;
        chk("commit_clean", 64'(commit_o), 64'd1);
        @(posedge clk); #1;
        wb_valid_i = 1'b0;
        chk("stay_idle", 64'(wb_ready_o), 64'd1);
        @(posedge clk); #1;
        chk("no_redirect", 64'(redirect_valid_o), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wb_valid_i = 1'b1; wb_pc_i = 64'h40; wb_instr_i = 32'h13; wb_excp_i = 10'd0;
        wb_badaddr_i = '0; irq_i = 16'hFFFF; mie_rdata_i = '0;
        mstatus_mie_i = 1'b1; mstatus_mpie_i = 1'b0;
        mtvec_rdata_i = 64'h8000_1000; mepc_rdata_i = '0; redirect_ready_i = 1'b0;
        #22;
        // Reset state, with a valid instruction and active irq lines held during reset.
        chk("rst_ready", 64'(wb_ready_o), 64'd1);
        chk("rst_commit", 64'(commit_o), 64'd0);
        chk("rst_mip", 64'(mip_o), 64'd0);
        chk("rst_redir", 64'(redirect_valid_o), 64'd0);
        chk("rst_mstatus_wen", 64'(mstatus_wen_o), 64'd0);
        wb_valid_i = 1'b0; irq_i = '0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Illegal instruction.
        exp_trap(1'b1, 64'd2, 64'hFFFF_FFFF, 64'h8000_0010, 1'b0, 1'b1, 64'h8000_1000);
        do_trap(64'h8000_0010, 32'hFFFF_FFFF, 10'h004, 64'hBAD, 1'b0, 1, 1'b0);
        // if_bus + ilegl + ld_mis: if_bus wins, mtval is the bad address.
        exp_trap(1'b1, 64'd1, 64'hDEAD_0000, 64'h300, 1'b0, 1'b1, 64'h8000_1000);
        do_trap(64'h300, 32'h13, 10'h046, 64'hDEAD_0000, 1'b0, 0, 1'b0);
        // ld_mis + st_bus: ld_mis wins.
        exp_trap(1'b1, 64'd4, 64'h1234_5678, 64'h304, 1'b0, 1'b1, 64'h8000_1000);
        do_trap(64'h304, 32'h13, 10'h240, 64'h1234_5678, 1'b0, 2, 1'b0);
        // ecall: mtval 0. Mode bits 2'b11 are ignored and the exception goes to base.
        mtvec_rdata_i = 64'h8000_1003;
        exp_trap(1'b1, 64'd11, 64'd0, 64'h308, 1'b0, 1'b1, 64'h8000_1000);
        do_trap(64'h308, 32'h73, 10'h008, 64'hFFFF, 1'b0, 0, 1'b0);
        // Clean instruction retires without a trap.
        do_commit(64'h30C);

        // Interrupt pending but globally disabled: plain commit.
        irq_i = 16'h0008; mie_rdata_i = 16'h0008; mstatus_mie_i = 1'b0;
        @(posedge clk); #1;
        chk("mip_sample", 64'(mip_o), 64'h0008);
        do_commit(64'h310);

        // Lines 1,3,7 raised, 3 and 7 enabled: line 3 (cause 19) wins.
        // irq drops after acceptance. The ack arrives after 5 extra cycles.
        irq_i = 16'h008A; mie_rdata_i = 16'h0088; mstatus_mie_i = 1'b1;
        mtvec_rdata_i = 64'h1001;
        @(posedge clk); #1;
        chk("mip_sample2", 64'(mip_o), 64'h008A);
`ifdef WB_TRAP_VECTORED_EN
        exp_trap(1'b1, 64'h8000_0000_0000_0013, 64'd0, 64'h104, 1'b0, 1'b1, 64'h104C);
`else
        exp_trap(1'b1, 64'h8000_0000_0000_0013, 64'd0, 64'h104, 1'b0, 1'b1, 64'h1000);
`endif
        do_trap(64'h100, 32'h13, 10'd0, 64'h55, 1'b1, 5, 1'b1);

        // Interrupt at the top of the address space: mepc wraps to 0.
        irq_i = 16'h0001; mie_rdata_i = 16'hFFFF; mtvec_rdata_i = 64'h2000;
        @(posedge clk); #1;
        exp_trap(1'b1, 64'h8000_0000_0000_0010, 64'd0, 64'd0, 1'b0, 1'b1, 64'h2000);
        do_trap(64'hFFFF_FFFF_FFFF_FFFC, 32'h13, 10'd0, 64'd0, 1'b1, 0, 1'b1);

        // mret with an interrupt pending: mret wins and only mstatus is written.
        irq_i = 16'h0008; mie_rdata_i = 16'h0008; mstatus_mpie_i = 1'b1; mepc_rdata_i = 64'h200;
        @(posedge clk); #1;
        exp_trap(1'b0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'h200);
        do_trap(64'h400, 32'h3020_0073, 10'h020, 64'd0, 1'b0, 1, 1'b0);
        // ebreak + mret: the exception beats mret.
        exp_trap(1'b1, 64'd3, 64'd0, 64'h404, 1'b0, 1'b1, 64'h2000);
        do_trap(64'h404, 32'h0010_0073, 10'h030, 64'h77, 1'b0, 0, 1'b1);

        // Reset asserted in the middle of REDIRECT.
        mstatus_mpie_i = 1'b0; mtvec_rdata_i = 64'h3000;
        exp_trap(1'b1, 64'd2, 64'h1234_5678, 64'h600, 1'b0, 1'b1, 64'h3000);
        wait_ready();
        drive(64'h600, 32'h1234_5678, 10'h004, 64'd0);
        @(posedge clk); #1;
        wb_valid_i = 1'b0; wb_excp_i = 10'd0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_mid_redir_valid", 64'(redirect_valid_o), 64'd0);
        chk("rst_mid_redir_pc", redirect_pc_o, 64'd0);
        chk("rst_mid_redir_ready", 64'(wb_ready_o), 64'd1);
        @(negedge clk); @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        exp_trap(1'b1, 64'd2, 64'h1, 64'h500, 1'b0, 1'b1, 64'h3000);
        do_trap(64'h500, 32'h0000_0001, 10'h004, 64'd0, 1'b0, 1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("trap_q_empty", 64'(trap_q.size()), 64'd0);
        chk("redir_q_empty", 64'(redir_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
